// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the fetch PC and drives a single-outstanding request/response
// instruction-memory port. Feeds instruction, PC and PC+4 to decode.
// Build option: define FETCH_DELAY_SLOT_EN for a MIPS-style branch delay
// slot. When it is undefined, an accepted redirect squashes the wrong-path
// fetch and inserts a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        redirectD,
    input  logic [31:0] redirect_pcD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pc_plus4D,
    output logic        validD
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] hold_instr;
`ifdef FETCH_DELAY_SLOT_EN
    logic        pend_vld;
    logic [31:0] pend_pc;
    logic [31:0] next_pc_load;
`else
    logic        kill;
`endif

    logic        stall_any;
    logic        redir_acc;
    logic        gnt_hs;
    logic        rsp_live;
    logic        load_mem;
    logic        load_hold;
    logic        load_if;
    logic        leave_hold;
    logic [31:0] load_instr;
    logic [31:0] pc_plus4F;

    // The fetch address is always the current PC; it only matters while imem_req=1.
    assign imem_addr = pcF;

    // Decode this cycle's events: handshake, usable response, IF/ID load source.
    always_comb begin
        stall_any  = stallF | stallD;
        redir_acc  = redirectD & ~stallD;
        gnt_hs     = (state == S_REQ) & imem_req & imem_gnt;
        pc_plus4F  = pcF + 32'd4;
`ifdef FETCH_DELAY_SLOT_EN
        // Nothing is squashed: every response belongs to the program stream.
        rsp_live   = (state == S_WAIT) & imem_rvalid;
        load_hold  = (state == S_HOLD) & ~stall_any;
        leave_hold = load_hold;
`else
        // A stale (killed) response or one racing a redirect is dropped.
        rsp_live   = (state == S_WAIT) & imem_rvalid & ~kill & ~redir_acc;
        load_hold  = (state == S_HOLD) & ~stall_any & ~redir_acc;
        leave_hold = (state == S_HOLD) & (~stall_any | redir_acc);
`endif
        load_mem   = rsp_live & ~stall_any;
        load_if    = load_mem | load_hold;
        load_instr = (state == S_HOLD) ? hold_instr : imem_rdata;
`ifdef FETCH_DELAY_SLOT_EN
        // The delay-slot load steers the PC to the branch target.
        if (redir_acc) begin
            next_pc_load = redirect_pcD;
        end else if (pend_vld) begin
            next_pc_load = pend_pc;
        end else begin
            next_pc_load = pc_plus4F;
        end
`endif
    end

    // Fetch FSM, PC, redirect bookkeeping and the IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_REQ;
            imem_req   <= 1'b0;
            pcF        <= RESET_PC;
            hold_instr <= 32'h0;
            instrD     <= 32'h0;
            pcD        <= 32'h0;
            pc_plus4D  <= 32'h0;
            validD     <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_vld   <= 1'b0;
            pend_pc    <= 32'h0;
`else
            kill       <= 1'b0;
`endif
        end else begin
            // ---- IF/ID register: hold on stallD, else load or bubble ----
            if (!stallD) begin
                if (load_if) begin
                    instrD    <= load_instr;
                    pcD       <= pcF;
                    pc_plus4D <= pc_plus4F;
                    validD    <= 1'b1;
                end else begin
                    instrD    <= 32'h0;
                    validD    <= 1'b0;
                end
            end

            // ---- fetch FSM; imem_req is registered with the state ----
            case (state)
                S_REQ: begin
                    if (gnt_hs) begin
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (rsp_live && stall_any) begin
                            hold_instr <= imem_rdata;
                            state      <= S_HOLD;
                        end else begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (leave_hold) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b0;
                end
            endcase

            // ---- PC update and redirect tracking ----
`ifdef FETCH_DELAY_SLOT_EN
            if (load_if) begin
                pcF      <= next_pc_load;
                pend_vld <= 1'b0;
            end else if (redir_acc) begin
                pend_vld <= 1'b1;
                pend_pc  <= redirect_pcD;
            end
`else
            if (redir_acc) begin
                pcF <= redirect_pcD;
            end else if (load_if) begin
                pcF <= pc_plus4F;
            end
            // A redirect with a fetch in flight marks its response as stale.
            if (state == S_WAIT && imem_rvalid) begin
                kill <= 1'b0;
            end else if (redir_acc && (gnt_hs || state == S_WAIT)) begin
                kill <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a
// program-stream reference model and a behavioural instruction memory.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stallF = 1'b0;
    logic        stallD = 1'b0;
    logic        redirectD = 1'b0;
    logic [31:0] redirect_pcD = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pcF;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pc_plus4D;
    logic        validD;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallF       (stallF),
        .stallD       (stallD),
        .redirectD    (redirectD),
        .redirect_pcD (redirect_pcD),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .pcF          (pcF),
        .instrD       (instrD),
        .pcD          (pcD),
        .pc_plus4D    (pc_plus4D),
        .validD       (validD)
    );

    int total = 0;
    int bad = 0;

    // Per-cycle stimulus knobs
    logic        stall_c = 1'b0;
    logic        redir_c = 1'b0;
    logic        gnt_en = 1'b1;
    logic [31:0] tgt_c = 32'h0;
    int          lat_c = 1;

    // Memory model: one outstanding request, response lat_c cycles after grant
    logic        mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] gq[$];

    // Program-stream model: PC of the next instruction decode must receive
    logic [31:0] exp_pc = RST_PC;
    logic        delivered = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
    logic        pend = 1'b0;
    logic [31:0] pend_tgt = 32'h0;
`endif

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, advance, update memory and stream model.
    task automatic step();
        logic        sd;
        logic        ra;
        logic        granted;
        logic [31:0] tg;
        logic [31:0] gaddr;
        logic [31:0] s_instr;
        logic [31:0] s_pc;
        logic [31:0] s_pc4;
        logic        s_vld;
        delivered   = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mem_busy && mem_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(mem_addr);
        end
        imem_gnt     = imem_req && !mem_busy && gnt_en;
        stallF       = stall_c;
        stallD       = stall_c;
        redirectD    = redir_c;
        redirect_pcD = tgt_c;
        sd      = stall_c;
        ra      = redir_c & ~stall_c;
        tg      = tgt_c;
        granted = imem_gnt;
        gaddr   = imem_addr;
        s_instr = instrD;
        s_pc    = pcD;
        s_pc4   = pc_plus4D;
        s_vld   = validD;
        @(posedge clk);
        #1;
        if (mem_busy) begin
            if (mem_wait == 0) mem_busy = 1'b0;
            else mem_wait--;
        end
        if (granted) begin
            mem_busy = 1'b1;
            mem_wait = lat_c - 1;
            mem_addr = gaddr;
            gq.push_back(gaddr);
        end
        if (sd) begin
            chk("hold_instrD", instrD, s_instr);
            chk("hold_pcD", pcD, s_pc);
            chk("hold_pc_plus4D", pc_plus4D, s_pc4);
            chk("hold_validD", 32'(validD), 32'(s_vld));
        end else begin
`ifdef FETCH_DELAY_SLOT_EN
            if (validD) begin
                chk("ds_pcD", pcD, exp_pc);
                chk("ds_instrD", instrD, memword(exp_pc));
                chk("ds_pc_plus4D", pc_plus4D, exp_pc + 32'd4);
                exp_pc    = ra ? tg : (pend ? pend_tgt : exp_pc + 32'd4);
                pend      = 1'b0;
                delivered = 1'b1;
            end else begin
                chk("bubble_instrD", instrD, 32'h0);
                if (ra) begin
                    pend     = 1'b1;
                    pend_tgt = tg;
                end
            end
`else
            if (ra) begin
                chk("redir_bubble_validD", 32'(validD), 32'd0);
                chk("redir_bubble_instrD", instrD, 32'h0);
                exp_pc = tg;
            end else if (validD) begin
                chk("pcD", pcD, exp_pc);
                chk("instrD", instrD, memword(exp_pc));
                chk("pc_plus4D", pc_plus4D, exp_pc + 32'd4);
                exp_pc    = exp_pc + 32'd4;
                delivered = 1'b1;
            end else begin
                chk("bubble_instrD", instrD, 32'h0);
            end
`endif
        end
    endtask

    task automatic wait_req();
        stall_c = 1'b0;
        redir_c = 1'b0;
        gnt_en  = 1'b0;
        for (int i = 0; i < 12 && !imem_req; i++) step();
        chk("wait_req_timeout", 32'(imem_req), 32'd1);
    endtask

    task automatic run_until_delivery(input string tag);
        logic got;
        got     = 1'b0;
        stall_c = 1'b0;
        redir_c = 1'b0;
        gnt_en  = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = delivered;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_pc;
        logic [31:0] pc0;
        logic [31:0] d1;
        logic [31:0] d2;

        // Reset values
        @(posedge clk);
        #1;
        chk("rst_pcF", pcF, RST_PC);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_instrD", instrD, 32'h0);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_pc_plus4D", pc_plus4D, 32'h0);
        chk("rst_validD", 32'(validD), 32'd0);
        rst_n = 1'b1;

        // Straight-line fetch: gnt=1, 1-cycle latency
        gnt_en = 1'b1;
        lat_c  = 1;
        step();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RST_PC);
        step();
        step();
        chk("first_validD", 32'(validD), 32'd1);
        chk("first_pcD", pcD, RST_PC);
        for (int i = 0; i < 4; i++) step();
        chk("grant_count", 32'(gq.size() >= 3), 32'd1);
        chk("grant_addr0", gq[0], RST_PC);
        chk("grant_addr1", gq[1], RST_PC + 32'd4);
        chk("grant_addr2", gq[2], RST_PC + 32'd8);

        // Response arrives during a 3-cycle stall
        wait_req();
        gnt_en = 1'b1;
        lat_c  = 1;
        step();
        stall_c = 1'b1;
        step();
        step();
        step();
        chk("hold_req_low", 32'(imem_req), 32'd0);
        held_pc = pcF;
        stall_c = 1'b0;
        step();
        chk("hold_release_validD", 32'(validD), 32'd1);
        chk("hold_release_instrD", instrD, memword(held_pc));
        chk("hold_release_pcD", pcD, held_pc);
        wait_req();
        chk("hold_next_addr", imem_addr, held_pc + 32'd4);

`ifndef FETCH_DELAY_SLOT_EN
        // Redirect while a fetch is outstanding
        wait_req();
        gnt_en = 1'b1;
        lat_c  = 2;
        step();
        redir_c = 1'b1;
        tgt_c   = 32'h0000_0200;
        step();
        chk("wait_redir_validD", 32'(validD), 32'd0);
        redir_c = 1'b0;
        step();
        chk("killed_rsp_validD", 32'(validD), 32'd0);
        wait_req();
        chk("redir_fetch_addr", imem_addr, 32'h0000_0200);
        lat_c = 1;
        run_until_delivery("redir_delivery_timeout");
        chk("redir_pcD", pcD, 32'h0000_0200);

        // Redirect ignored while stallD=1, accepted once released
        wait_req();
        pc0     = pcF;
        stall_c = 1'b1;
        redir_c = 1'b1;
        tgt_c   = 32'h0000_0300;
        step();
        chk("stalled_redir_pcF0", pcF, pc0);
        step();
        chk("stalled_redir_pcF1", pcF, pc0);
        stall_c = 1'b0;
        step();
        chk("released_redir_pcF", pcF, 32'h0000_0300);
        redir_c = 1'b0;
        run_until_delivery("stall_redir_delivery_timeout");
        chk("stall_redir_pcD", pcD, 32'h0000_0300);

        // PC wraps modulo 2^32
        wait_req();
        redir_c = 1'b1;
        tgt_c   = 32'hFFFF_FFF8;
        step();
        redir_c = 1'b0;
        run_until_delivery("wrap_d0_timeout");
        run_until_delivery("wrap_d1_timeout");
        chk("wrap_pcD", pcD, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4D", pc_plus4D, 32'h0);
        run_until_delivery("wrap_d2_timeout");
        chk("wrap_next_pcD", pcD, 32'h0);
`else
        // Delay slot: the instruction after the branch is delivered, then the target
        run_until_delivery("ds_branch_timeout");
        pc0     = pcD;
        redir_c = 1'b1;
        tgt_c   = 32'h0000_0040;
        gnt_en  = 1'b1;
        step();
        redir_c = 1'b0;
        if (!delivered) run_until_delivery("ds_slot_timeout");
        d1 = pcD;
        run_until_delivery("ds_target_timeout");
        d2 = pcD;
        chk("ds_slot_pc", d1, pc0 + 32'd4);
        chk("ds_target_pc", d2, 32'h0000_0040);
`endif

        // Randomized traffic against the stream model
        for (int i = 0; i < 1500; i++) begin
            stall_c = ($urandom_range(0, 99) < 20);
            redir_c = ($urandom_range(0, 99) < 6);
            tgt_c   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            gnt_en  = ($urandom_range(0, 99) < 70);
            lat_c   = $urandom_range(1, 3);
            step();
        end
        lat_c = 1;
        run_until_delivery("random_tail_timeout");

        // Asynchronous reset while a fetch is outstanding
        wait_req();
        gnt_en = 1'b1;
        lat_c  = 3;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_pcF", pcF, RST_PC);
        chk("async_imem_req", 32'(imem_req), 32'd0);
        chk("async_instrD", instrD, 32'h0);
        chk("async_pcD", pcD, 32'h0);
        chk("async_pc_plus4D", pc_plus4D, 32'h0);
        chk("async_validD", 32'(validD), 32'd0);
        mem_busy     = 1'b0;
        mem_wait     = 0;
        exp_pc       = RST_PC;
`ifdef FETCH_DELAY_SLOT_EN
        pend         = 1'b0;
`endif
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        stall_c      = 1'b0;
        redir_c      = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        gnt_en = 1'b1;
        lat_c  = 1;
        step();
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, RST_PC);
        run_until_delivery("post_rst_delivery_timeout");
        chk("post_rst_pcD", pcD, RST_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus the IF/ID pipeline register. Owns the PC and drives a single-outstanding request/response instruction-memory port. Delivers instruction, PC and PC+4 to decode. Consumes `stallF`/`stallD` from the hazard detection unit and branch/jump redirects resolved in decode; inserts NOP bubbles into IF/ID where required.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stallF` input 1: hold PC (hazard unit).
- `stallD` input 1: hold IF/ID (hazard unit).
- `redirectD` input 1: taken branch or jump resolved in decode this cycle.
- `redirect_pcD` input 32: redirect target.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output 32: fetch address; equals `pcF` while `imem_req`=1.
- `imem_gnt` input 1: request accepted this cycle.
- `imem_rvalid` input 1: response valid.
- `imem_rdata` input 32: instruction word.
- `pcF` output 32: current fetch PC.
- `instrD` output 32: IF/ID instruction; 32'h0 (NOP) when `validD`=0.
- `pcD` output 32: IF/ID PC.
- `pc_plus4D` output 32: IF/ID PC+4.
- `validD` output 1: IF/ID holds a real instruction.

## Operation
- Clock and reset are as listed above: one clock (`clk`); reset `rst_n` is asynchronous and active-low.
- FSM states:
  - **REQ**: `imem_req`=1. On `imem_gnt` → WAIT.
  - **WAIT**: `imem_req`=0, one request outstanding. On `imem_rvalid`, behaviour depends on conditions:
    - If the kill flag is set: discard the data, clear the kill flag → REQ.
    - Else if `stallF|stallD`: capture the data into the hold buffer → HOLD.
    - Else: load IF/ID (`instrD`=rdata, `pcD`=`pcF`, `pc_plus4D`=`pcF`+4, `validD`=1), set `pcF`←`pcF`+4 → REQ.
  - **HOLD**: `imem_req`=0. When `stallF|stallD`=0: load IF/ID from the hold buffer, set `pcF`←`pcF`+4 → REQ.
- IF/ID is held unchanged whenever `stallD`=1. When no new instruction is loaded and `stallD`=0, IF/ID becomes a bubble (`validD`=0, `instrD`=0).
- A redirect is accepted only when `redirectD`=1 and `stallD`=0. While `stallD`=1, `redirectD` is ignored; the hazard unit keeps the branch in decode.
- Accepted redirect, without delay slot:
  - `pcF`←`redirect_pcD`.
  - IF/ID becomes a bubble next cycle.
  - In REQ with `imem_gnt`=1 the same cycle, or in WAIT with no `imem_rvalid` this cycle: set the kill flag.
  - In WAIT with `imem_rvalid` this cycle: drop the data → REQ.
  - In HOLD: drop the hold buffer → REQ.
- Redirect has priority over the sequential `pcF`+4 update in every state.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). No alignment checking.
- Throughput: at most one instruction per two cycles (REQ→WAIT→REQ).

## Timing
- Reset values:
  - `pcF`=`RESET_PC`, `imem_req`=0, `instrD`=0, `pcD`=0, `pc_plus4D`=0, `validD`=0.
  - Kill flag=0, hold buffer empty, state=REQ.
- The first `imem_req`=1 occurs in the first cycle after `rst_n` deasserts.
- `rst_n` asserted mid-transaction returns all state to reset values immediately. The instruction memory shares `rst_n`, so no stale response arrives after release.
- Response latency ≥1 cycle after grant. Exactly one in-order response is returned per grant.
- Fetch-to-decode latency: IF/ID is updated on the edge at which `imem_rvalid`=1 is sampled, when there is no stall.
- `imem_rvalid` and `redirectD` in the same cycle: the redirect wins and the response is discarded (non-delay-slot build).
- `stallF`=1 with `stallD`=0 cannot occur from the hazard unit. If it does, the PC is held and IF/ID is bubbled.

## Configuration
- `FETCH_DELAY_SLOT_EN`:
  - **Defined**: MIPS branch delay slot. An accepted redirect stores `redirect_pcD` as a pending target; nothing is killed and no bubble is inserted. The next instruction loaded into IF/ID (the delay slot, at branch PC+4) is delivered normally. On that load, `pcF`←pending target instead of `pcF`+4, and the pending state is cleared.
  - **Not defined**: squash behaviour as described in Operation.

## Test plan
- Reset with `RESET_PC`=32'h0000_0100, `imem_gnt`=1, 1-cycle response latency → `imem_addr` sequence 0x100, 0x104, 0x108. `validD`=1 with `pcD`=0x100 on the third cycle after release.
- Response arrives while `stallD`=`stallF`=1 for 3 cycles → FSM in HOLD, IF/ID unchanged. On release, `instrD`=held word and the next `imem_addr`=`pcF`+4.
- Non-delay-slot build: `redirectD`=1, target 0x200, while in WAIT → the next response is discarded, `validD`=0 next cycle, the next fetch goes to 0x200.
- `FETCH_DELAY_SLOT_EN` build: branch at 0x10 redirects to 0x40 → IF/ID delivers 0x14, then the fetch address becomes 0x40. No bubble.
- `redirectD`=1 while `stallD`=1 → ignored, `pcF` unchanged. The redirect is accepted on the first cycle with `stallD`=0.
- `rst_n` pulled low during WAIT → all outputs return to reset values asynchronously; a fresh fetch at `RESET_PC` starts after release.
